// File: rtl/dac081s101.sv
// SPI write master for the DAC081S101: latches {00, pd, code, 0000} on a start
// strobe and shifts it out MSB first on SYNC/SCLK/DIN, then holds SYNC high to recover.
module dac081s101 #(
  parameter int CLK_DIV   = 4,
  parameter int SYNC_HIGH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startWrite,
  input  logic [1:0] pd,
  input  logic [7:0] datain,
  output logic       busy,
  output logic       writeComplete,
  output logic       sync,
  output logic       sclk,
  output logic       mosi
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(SYNC_HIGH - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETUP   = 2'd1;
  localparam logic [1:0] ST_SHIFT   = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] hcnt;
  logic [4:0]       bcnt;
  logic [15:0]      shreg;
  logic [15:0]      frame;

  assign frame = {2'b00, pd, datain, 4'b0000};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      hcnt          <= '0;
      bcnt          <= '0;
      shreg         <= '0;
      busy          <= 1'b0;
      writeComplete <= 1'b0;
      sync          <= 1'b1;
      sclk          <= 1'b1;
      mosi          <= 1'b0;
    end else begin
      writeComplete <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (startWrite) begin
            shreg <= frame;
            mosi  <= frame[15];
            busy  <= 1'b1;
            sync  <= 1'b0;
            sclk  <= 1'b1;
            hcnt  <= '0;
            bcnt  <= '0;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (hcnt == DIV_LAST) begin
            hcnt  <= '0;
            sclk  <= 1'b0;
            state <= ST_SHIFT;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (hcnt == DIV_LAST) begin
            hcnt <= '0;
            // Data advances only on the rising edge so DIN is stable across each fall.
            if (!sclk) begin
              sclk  <= 1'b1;
              shreg <= {shreg[14:0], shreg[15]};
              mosi  <= shreg[14];
            end else if (bcnt == 5'd15) begin
              sync          <= 1'b1;
              mosi          <= 1'b0;
              writeComplete <= 1'b1;
              state         <= ST_RECOVER;
            end else begin
              bcnt <= bcnt + 5'd1;
              sclk <= 1'b0;
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        ST_RECOVER: begin
          if (hcnt == REC_LAST) begin
            hcnt  <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac081s101.sv
// Randomised bench for dac081s101: records each frame cycle by cycle and checks it
// against a timing formula and a DAC-side model that samples DIN on SCLK falls.
module tb_dac081s101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_a, start_b;
  logic [1:0] pd_a, pd_b;
  logic [7:0] data_a, data_b;
  logic       busy_a, wc_a, sync_a, sclk_a, mosi_a;
  logic       busy_b, wc_b, sync_b, sclk_b, mosi_b;

  dac081s101 #(.CLK_DIV(4), .SYNC_HIGH(2)) u_dut_a (
    .clk(clk), .reset(reset), .startWrite(start_a), .pd(pd_a), .datain(data_a),
    .busy(busy_a), .writeComplete(wc_a), .sync(sync_a), .sclk(sclk_a), .mosi(mosi_a)
  );

  dac081s101 #(.CLK_DIV(1), .SYNC_HIGH(1)) u_dut_b (
    .clk(clk), .reset(reset), .startWrite(start_b), .pd(pd_b), .datain(data_b),
    .busy(busy_b), .writeComplete(wc_b), .sync(sync_b), .sclk(sclk_b), .mosi(mosi_b)
  );

  int checks = 0;
  int errors = 0;

  logic s_sync [0:399];
  logic s_sclk [0:399];
  logic s_mosi [0:399];
  logic s_busy [0:399];
  logic s_wc   [0:399];

  logic [15:0] q_word [$];
  int          q_falls [$];
  int          viol;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(int sel, logic st, logic [1:0] p, logic [7:0] d);
    if (sel == 0) begin start_a = st; pd_a = p; data_a = d; end
    else          begin start_b = st; pd_b = p; data_b = d; end
  endtask

  task automatic drop_start(int sel);
    if (sel == 0) start_a = 1'b0;
    else          start_b = 1'b0;
  endtask

  task automatic sample(int sel, int j);
    if (sel == 0) begin
      s_sync[j] = sync_a; s_sclk[j] = sclk_a; s_mosi[j] = mosi_a; s_busy[j] = busy_a; s_wc[j] = wc_a;
    end else begin
      s_sync[j] = sync_b; s_sclk[j] = sclk_b; s_mosi[j] = mosi_b; s_busy[j] = busy_b; s_wc[j] = wc_b;
    end
  endtask

  // Index j = cycles after the edge that accepted the start strobe.
  task automatic frame(int sel, logic [1:0] p, logic [7:0] d, int n,
                       int inj1, int inj2, logic [1:0] p2, logic [7:0] d2);
    @(negedge clk);
    sample(sel, 0);
    drive(sel, 1'b1, p, d);
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      sample(sel, j);
      drop_start(sel);
      if (j == inj1 || j == inj2) drive(sel, 1'b1, p2, d2);
    end
  endtask

  function automatic logic exp_sclk(int j, int d);
    if (j <= d || j > 33 * d) return 1'b1;
    return (((j - d - 1) / d) % 2) == 1;
  endfunction

  // DAC-side view: shift DIN in on each SCLK fall while SYNC is low, emit word on SYNC rise.
  task automatic dac_model(int n);
    logic [15:0] sh;
    int nf;
    bit in_frame;
    q_word.delete(); q_falls.delete();
    viol = 0; in_frame = 0; sh = '0; nf = 0;
    for (int j = 1; j <= n; j++) begin
      if (s_sync[j] == 1'b0) begin
        if (!in_frame) begin in_frame = 1; sh = '0; nf = 0; end
        if (s_sclk[j-1] == 1'b1 && s_sclk[j] == 1'b0) begin
          sh = {sh[14:0], s_mosi[j-1]};
          nf++;
        end
        if (s_sync[j-1] == 1'b0 && s_sclk[j] == 1'b0 && s_mosi[j] != s_mosi[j-1]) viol++;
      end else if (in_frame) begin
        in_frame = 0;
        q_word.push_back(sh);
        q_falls.push_back(nf);
      end
    end
  endtask

  task automatic check_timing(int d, int sh, int base);
    int ms, mk, mb, mw, fall;
    ms = 0; mk = 0; mb = 0; mw = 0; fall = -1;
    for (int j = 1; j <= 33 * d + sh + 1; j++) begin
      if (s_sync[base+j] != (j > 33 * d))         ms++;
      if (s_sclk[base+j] != exp_sclk(j, d))       mk++;
      if (s_busy[base+j] != (j <= 33 * d + sh))   mb++;
      if (s_wc[base+j]   != (j == 33 * d + 1))    mw++;
      if (fall < 0 && s_busy[base+j] == 1'b0)     fall = j;
    end
    chk("sync_wave", ms, 0);
    chk("sclk_wave", mk, 0);
    chk("busy_wave", mb, 0);
    chk("wc_wave", mw, 0);
    chk("busy_fall_cycle", fall, 33 * d + sh + 1);
  endtask

  task automatic check_single(int d, int sh, int n, logic [15:0] w);
    check_timing(d, sh, 0);
    dac_model(n);
    chk("frame_count", q_word.size(), 1);
    if (q_word.size() >= 1) begin
      chk("word", q_word[0], w);
      chk("falls", q_falls[0], 16);
    end
    chk("mosi_stable", viol, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  p, p2;
    logic [7:0]  d, d2;
    logic [15:0] w;
    int run, sel, dv, shv;

    reset = 1'b0;
    drive(0, 1'b0, 2'b00, 8'h00);
    drive(1, 1'b0, 2'b00, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_sync", sync_a, 1);
    chk("rst_sclk", sclk_a, 1);
    chk("rst_mosi", mosi_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_wc", wc_a, 0);
    chk("rst_sync_b", sync_b, 1);
    reset = 1'b1;
    @(negedge clk);

    // Nominal frame, 8'hA5
    frame(0, 2'b00, 8'hA5, 140, -1, -1, 2'b00, 8'h00);
    check_single(4, 2, 140, 16'h0A50);
    chk("t1_sync_last_low", s_sync[132], 0);
    chk("t1_wc_133", s_wc[133], 1);
    chk("t1_busy_134", s_busy[134], 1);
    chk("t1_busy_135", s_busy[135], 0);

    // Power-down high-Z
    frame(0, 2'b11, 8'h00, 140, -1, -1, 2'b00, 8'h00);
    check_single(4, 2, 140, 16'h3000);
    if (q_word.size() >= 1) begin
      w = q_word[0];
      chk("t2_pd_mode", w[13:12], 3);
      if (w[13:12] == 2'b11) $display("dac model: high-Z power-down mode");
    end

    // Starts during a frame are ignored
    d = 8'($urandom_range(0, 255));
    p = 2'($urandom_range(0, 3));
    frame(0, p, d, 140, 10, 60, 2'b00, 8'hFF);
    check_single(4, 2, 140, {2'b00, p, d, 4'b0000});
    chk("t3_no_queued", s_sync[140], 1);

    // Mid-frame asynchronous reset
    frame(0, 2'b01, 8'h5A, 49, -1, -1, 2'b00, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t4_sync", sync_a, 1);
    chk("t4_sclk", sclk_a, 1);
    chk("t4_mosi", mosi_a, 0);
    chk("t4_busy", busy_a, 0);
    repeat (2) @(negedge clk);
    chk("t4_wc", wc_a, 0);
    reset = 1'b1;
    @(negedge clk);
    d = 8'($urandom_range(0, 255));
    frame(0, 2'b00, d, 140, -1, -1, 2'b00, 8'h00);
    check_single(4, 2, 140, {4'b0000, d, 4'b0000});

    // Back-to-back: second start in the cycle busy falls
    p = 2'($urandom_range(0, 3));  d = 8'($urandom_range(0, 255));
    p2 = 2'($urandom_range(0, 3)); d2 = 8'($urandom_range(0, 255));
    frame(0, p, d, 272, 135, -1, p2, d2);
    check_timing(4, 2, 0);
    check_timing(4, 2, 135);
    run = 0;
    for (int j = 133; j < 272 && s_sync[j] == 1'b1; j++) run++;
    chk("t5_sync_gap", run, 3);
    dac_model(272);
    chk("t5_frames", q_word.size(), 2);
    if (q_word.size() >= 2) begin
      chk("t5_word0", q_word[0], {2'b00, p, d, 4'b0000});
      chk("t5_word1", q_word[1], {2'b00, p2, d2, 4'b0000});
    end
    chk("t5_mosi_stable", viol, 0);

    // Fastest divider
    frame(1, 2'b00, 8'h3C, 40, -1, -1, 2'b00, 8'h00);
    check_single(1, 1, 40, 16'h03C0);
    chk("t6_sync_34", s_sync[34], 1);
    chk("t6_busy_35", s_busy[35], 0);

    // Random frames on both instances
    for (int t = 0; t < 6; t++) begin
      sel = t % 2;
      dv  = (sel == 0) ? 4 : 1;
      shv = (sel == 0) ? 2 : 1;
      p = 2'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 255));
      frame(sel, p, d, 33 * dv + shv + 3, -1, -1, 2'b00, 8'h00);
      check_single(dv, shv, 33 * dv + shv + 3, {2'b00, p, d, 4'b0000});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
